// File: rtl/muldiv_unit_pkg.sv
// Shared op and state encodings for the multiply/divide unit and its decode logic.
// Latency: n/a (types and pure helper functions only).
// Backpressure: n/a.
package muldiv_unit_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2
    } md_state_e;

    // Signed ops take magnitudes on entry and re-apply signs in the fix-up cycle.
    function automatic logic op_is_signed(input md_op_e o);
        return (o == MD_MULT) || (o == MD_DIV);
    endfunction

    function automatic logic op_is_div(input md_op_e o);
        return (o == MD_DIV) || (o == MD_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning HI/LO: one bit per cycle, sign fix-up at the end.
// Latency: start in cycle N -> done pulse with HI/LO updated in cycle N+WIDTH+2.
// Backpressure: busy high while an op is in flight; start and MTHI/MTLO are ignored then.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    // Two's-complement negate at operand width.
    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

    // Magnitude of a value whose sign has already been decided; |0x8000..0| stays representable.
    function automatic logic [WIDTH-1:0] mag_w(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? neg_w(v) : v;
    endfunction

    md_state_e          state_q, state_d;
    logic [CW-1:0]      count_q;
    logic [2*WIDTH-1:0] acc_q;      // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
    logic [WIDTH-1:0]   opa_q;      // |a|: multiplicand, or original dividend magnitude
    logic [WIDTH-1:0]   opb_q;      // |b|: divisor
    logic               sa_q, sb_q, is_div_q, b_zero_q;
    logic               done_q;
    logic [WIDTH-1:0]   hi_q, lo_q;

    md_op_e             op_e;
    logic               sa_in, sb_in;
    logic [WIDTH-1:0]   mag_a, mag_b;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift, div_diff;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    assign op_e  = md_op_e'(op);
    assign sa_in = op_is_signed(op_e) & src_a[WIDTH-1];
    assign sb_in = op_is_signed(op_e) & src_b[WIDTH-1];
    assign mag_a = mag_w(src_a, sa_in);
    assign mag_b = mag_w(src_b, sb_in);

    assign busy = (state_q != MD_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= MD_IDLE;
        else     state_q <= state_d;
    end

    // Next-state: launch on start, iterate WIDTH cycles, one fix-up cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            MD_IDLE: if (start) state_d = MD_CALC;
            MD_CALC: if (count_q == LAST) state_d = MD_FIX;
            MD_FIX:  state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
    end

    // One iteration step for each algorithm plus the sign fix-up of the finished result.
    always_comb begin
        // Shift-add: conditionally add multiplicand to the upper half, then shift right with carry.
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opa_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};

        // Restoring divide: remainder stays below divisor, so bit WIDTH of the difference is the borrow.
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opb_q};
        div_next  = div_diff[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

        prod_fixed = (sa_q ^ sb_q) ? (~acc_q + (2*WIDTH)'(1)) : acc_q;

        fix_hi = prod_fixed[2*WIDTH-1:WIDTH];
        fix_lo = prod_fixed[WIDTH-1:0];
        if (is_div_q) begin
            if (b_zero_q) begin
                // Divide by zero leaves the dividend in HI untouched and saturates LO.
                fix_hi = mag_w(opa_q, sa_q);
                fix_lo = '1;
            end else begin
                fix_hi = mag_w(acc_q[2*WIDTH-1:WIDTH], sa_q);
                fix_lo = mag_w(acc_q[WIDTH-1:0], sa_q ^ sb_q);
            end
        end
    end

    // Datapath: operand capture, iteration, HI/LO writes and the done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= '0;
            acc_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            is_div_q <= 1'b0;
            b_zero_q <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            done_q <= (state_q == MD_FIX);
            case (state_q)
                MD_IDLE: begin
                    if (hi_we) hi_q <= wdata;
                    if (lo_we) lo_q <= wdata;
                    if (start) begin
                        opa_q    <= mag_a;
                        opb_q    <= mag_b;
                        sa_q     <= sa_in;
                        sb_q     <= sb_in;
                        is_div_q <= op_is_div(op_e);
                        b_zero_q <= (src_b == '0);
                        count_q  <= '0;
                        acc_q    <= op_is_div(op_e) ? {{WIDTH{1'b0}}, mag_a}
                                                    : {{WIDTH{1'b0}}, mag_b};
                    end
                end
                MD_CALC: begin
                    acc_q <= is_div_q ? div_next : mul_next;
                    if (count_q != LAST) count_q <= count_q + CW'(1);
                end
                MD_FIX: begin
                    hi_q <= fix_hi;
                    lo_q <= fix_lo;
                end
                default: ;
            endcase
        end
    end

endmodule
